// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: one AXI read port (AR + R channels).
// The arbiter connects to masters through the slave modport and to the shared slave through the master modport.
interface axi_rd_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [SIZE_W-1:0] ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    modport master (output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
                    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
    modport slave  (input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
                    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one slave read port between M0 and M1.
// One outstanding burst; R beats are routed by the latched grant and counted against ARLEN.
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    axi_rd_arbiter_if.slave  m0,
    axi_rd_arbiter_if.slave  m1,
    axi_rd_arbiter_if.master s,
    output logic             len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d, last_q, last_d, len_err_q, len_err_d;
    logic [IDS_W-1:0]  arid_q, arid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d, beat_q, beat_d;
    logic [SIZE_W-1:0] arsize_q, arsize_d;
    logic [1:0]        arburst_q, arburst_d;
    logic              idle, data, win, sel0, sel1, beat;

    // Gating with ARESETn keeps ARREADY low while reset is held.
    assign idle = (state_q == IDLE) & ARESETn;
    assign data = state_q == DATA;
    assign win  = (m0.ARVALID & m1.ARVALID) ? ~last_q : m1.ARVALID;
    assign sel0 = data & ~grant_q;
    assign sel1 = data & grant_q;
    assign beat = s.RVALID & s.RREADY;

    assign m0.ARREADY = idle & m0.ARVALID & ~win;
    assign m1.ARREADY = idle & m1.ARVALID & win;

    assign s.ARVALID = state_q == ADDR;
    assign s.ARID    = arid_q;
    assign s.ARADDR  = araddr_q;
    assign s.ARLEN   = arlen_q;
    assign s.ARSIZE  = arsize_q;
    assign s.ARBURST = arburst_q;
    assign s.RREADY  = data & (grant_q ? m1.RREADY : m0.RREADY);

    assign m0.RVALID = sel0 & s.RVALID;
    assign m0.RID    = sel0 ? s.RID[ID_W-1:0] : '0;
    assign m0.RDATA  = sel0 ? s.RDATA : '0;
    assign m0.RRESP  = sel0 ? s.RRESP : '0;
    assign m0.RLAST  = sel0 & s.RLAST;
    assign m1.RVALID = sel1 & s.RVALID;
    assign m1.RID    = sel1 ? s.RID[ID_W-1:0] : '0;
    assign m1.RDATA  = sel1 ? s.RDATA : '0;
    assign m1.RRESP  = sel1 ? s.RRESP : '0;
    assign m1.RLAST  = sel1 & s.RLAST;

    assign len_err = len_err_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        beat_d    = beat_q;
        len_err_d = 1'b0;
        if (idle && (m0.ARVALID || m1.ARVALID)) begin
            state_d   = ADDR;
            grant_d   = win;
            arid_d    = {(IDS_W-ID_W)'(win), win ? m1.ARID : m0.ARID};
            araddr_d  = win ? m1.ARADDR : m0.ARADDR;
            arlen_d   = win ? m1.ARLEN : m0.ARLEN;
            arsize_d  = win ? m1.ARSIZE : m0.ARSIZE;
            arburst_d = win ? m1.ARBURST : m0.ARBURST;
        end
        if (s.ARVALID && s.ARREADY) begin
            state_d = DATA;
            beat_d  = '0;
        end
        if (beat) begin
            beat_d    = beat_q + LEN_W'(1);
            // Error when RLAST and "this is beat ARLEN" disagree in either direction.
            len_err_d = s.RLAST ^ (beat_q == arlen_q);
            if (s.RLAST) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            beat_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            beat_q    <= beat_d;
            len_err_q <= len_err_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed test of grant order, routing, stalls, length check and reset.
module tb_axi_rd_arbiter;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic len_err;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 ACLK = ~ACLK;

    axi_rd_arbiter_if #(.ID_W(4)) m0_if ();
    axi_rd_arbiter_if #(.ID_W(4)) m1_if ();
    axi_rd_arbiter_if #(.ID_W(8)) s_if ();

    axi_rd_arbiter dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .len_err (len_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic idle_all();
        m0_if.ARVALID = 0; m1_if.ARVALID = 0;
        m0_if.RREADY = 0;  m1_if.RREADY = 0;
        m0_if.ARLEN = 0;   m1_if.ARLEN = 0;
        m0_if.ARSIZE = 3'd2; m1_if.ARSIZE = 3'd2;
        m0_if.ARBURST = 2'd1; m1_if.ARBURST = 2'd1;
        s_if.ARREADY = 0; s_if.RVALID = 0; s_if.RLAST = 0;
        s_if.RDATA = 0; s_if.RID = 0; s_if.RRESP = 0;
    endtask

    task automatic do_reset();
        ARESETn = 0;
        idle_all();
        cyc();
        ARESETn = 1;
        cyc();
    endtask

    // Caller raises the requests; g is the master expected to win.
    task automatic run_burst(input logic g, input int nb, input logic err, input int wait_n);
        logic [31:0] ea;
        logic [3:0]  eid, el;
        ea  = g ? m1_if.ARADDR : m0_if.ARADDR;
        eid = g ? m1_if.ARID : m0_if.ARID;
        el  = g ? m1_if.ARLEN : m0_if.ARLEN;
        #1;
        check("arready_win", g ? m1_if.ARREADY : m0_if.ARREADY, 1);
        check("arready_lose", g ? m0_if.ARREADY : m1_if.ARREADY, 0);
        cyc();
        if (g) m1_if.ARVALID = 0; else m0_if.ARVALID = 0;
        for (int i = 0; i <= wait_n; i++) begin
            #1;
            check("arvalid_s", s_if.ARVALID, 1);
            check("arid_s", s_if.ARID, {3'b000, g, eid});
            check("araddr_s", s_if.ARADDR, ea);
            check("arlen_s", s_if.ARLEN, el);
            check("arready_addr", {m0_if.ARREADY, m1_if.ARREADY}, 0);
            m0_if.ARADDR = ~m0_if.ARADDR;
            m1_if.ARADDR = ~m1_if.ARADDR;
            if (i == wait_n) s_if.ARREADY = 1;
            cyc();
        end
        s_if.ARREADY = 0;
        for (int b = 0; b < nb; b++) begin
            s_if.RVALID = 1;
            s_if.RLAST = (b == nb - 1);
            s_if.RDATA = 32'hA500 + b;
            s_if.RID = {4'hF, eid};
            m0_if.RREADY = 1;
            m1_if.RREADY = 1;
            #1;
            check("rvalid_g", g ? m1_if.RVALID : m0_if.RVALID, 1);
            check("rvalid_ng", g ? m0_if.RVALID : m1_if.RVALID, 0);
            check("rdata_g", g ? m1_if.RDATA : m0_if.RDATA, 32'hA500 + b);
            check("rdata_ng", g ? m0_if.RDATA : m1_if.RDATA, 0);
            check("rid_g", g ? m1_if.RID : m0_if.RID, eid);
            check("rlast_g", g ? m1_if.RLAST : m0_if.RLAST, b == nb - 1);
            check("rready_s", s_if.RREADY, 1);
            cyc();
        end
        s_if.RVALID = 0;
        s_if.RLAST = 0;
        m0_if.RREADY = 0;
        m1_if.RREADY = 0;
        #1;
        check("len_err", len_err, err);
    endtask

    initial begin
        int k, stall;
        logic rr;
        idle_all();
        m0_if.ARID = 4'h3;   m1_if.ARID = 4'hA;
        m0_if.ARADDR = 32'h0000_0010; m1_if.ARADDR = 32'h0000_2000;
        cyc();
        cyc();
        m0_if.ARVALID = 1;
        s_if.RVALID = 1;
        m0_if.RREADY = 1;
        #1;
        check("rst_arready", {m0_if.ARREADY, m1_if.ARREADY}, 0);
        check("rst_arvalid_s", s_if.ARVALID, 0);
        check("rst_rvalid", {m0_if.RVALID, m1_if.RVALID}, 0);
        check("rst_rready_s", s_if.RREADY, 0);
        check("rst_araddr_s", s_if.ARADDR, 0);
        check("rst_len_err", len_err, 0);
        idle_all();
        ARESETn = 1;
        cyc();

        // single M0 read, LEN 0
        m0_if.ARVALID = 1;
        run_burst(0, 1, 0, 0);

        // simultaneous requests alternate from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m0_if.ARVALID = 1;
            m1_if.ARVALID = 1;
            run_burst(i[0], 1, 0, 0);
        end
        m0_if.ARVALID = 0;

        // M1 LEN 3 burst with master back-pressure, M0 pending
        m1_if.ARLEN = 3;
        m1_if.ARVALID = 1;
        #1;
        check("m1_arready", m1_if.ARREADY, 1);
        cyc();
        m1_if.ARVALID = 0;
        m0_if.ARVALID = 1;
        s_if.ARREADY = 1;
        #1;
        check("m1_arvalid_s", s_if.ARVALID, 1);
        check("m0_stall_addr", m0_if.ARREADY, 0);
        cyc();
        s_if.ARREADY = 0;
        k = 0;
        stall = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            rr = !(k == 1 && stall < 2);
            s_if.RVALID = 1;
            s_if.RLAST = (k == 3);
            s_if.RDATA = k;
            m1_if.RREADY = rr;
            #1;
            check("rready_s_bp", s_if.RREADY, rr);
            check("rlast_m1", m1_if.RLAST, k == 3);
            check("m0_stall_data", m0_if.ARREADY, 0);
            if (!rr) stall++;
            if (s_if.RREADY && m1_if.RVALID) k++;
            cyc();
        end
        check("m1_beats", k, 4);
        s_if.RVALID = 0;
        s_if.RLAST = 0;
        m1_if.RREADY = 0;
        m1_if.ARLEN = 0;
        #1;
        check("m1_len_ok", len_err, 0);
        run_burst(0, 1, 0, 0);

        // early RLAST on beat 2 of a LEN 3 burst
        m0_if.ARLEN = 3;
        m0_if.ARVALID = 1;
        run_burst(0, 2, 1, 0);
        cyc();
        #1;
        check("len_err_pulse", len_err, 0);

        // beat ARLEN arrives without RLAST
        m0_if.ARLEN = 0;
        m1_if.ARVALID = 1;
        run_burst(1, 2, 1, 0);

        // ARREADY_S held low for 5 cycles
        m0_if.ARVALID = 1;
        m1_if.ARVALID = 1;
        run_burst(0, 1, 0, 5);
        run_burst(1, 1, 0, 0);

        // reset during DATA beat 2
        m0_if.ARVALID = 1;
        run_burst(0, 1, 0, 0);
        m0_if.ARLEN = 3;
        m0_if.ARVALID = 1;
        cyc();
        m0_if.ARVALID = 0;
        s_if.ARREADY = 1;
        cyc();
        s_if.ARREADY = 0;
        s_if.RVALID = 1;
        m0_if.RREADY = 1;
        cyc();
        #1;
        check("pre_rst_rvalid", m0_if.RVALID, 1);
        ARESETn = 0;
        #1;
        check("mid_rst_rvalid", {m0_if.RVALID, m1_if.RVALID}, 0);
        check("mid_rst_rready_s", s_if.RREADY, 0);
        check("mid_rst_arvalid_s", s_if.ARVALID, 0);
        idle_all();
        cyc();
        ARESETn = 1;
        m0_if.ARVALID = 1;
        m1_if.ARVALID = 1;
        run_burst(0, 1, 0, 0);
        run_burst(1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Per-slave AXI read-channel arbiter. Shares one slave read port (one SRAM_wrapper, IM or DM) between master M0 (instruction fetch) and master M1 (data read).
- Instantiated once per slave inside the AXI interconnect, after address decode.
- Round-robin grant; holds the grant for a full burst; routes R beats back to the granted master; checks burst length against LEN.

Parameters:
- ID_W, 4: master-side ID width (`AXI_ID_BITS).
- IDS_W, 8: slave-side ID width (`AXI_IDS_BITS) = {4-bit master tag, ID_W}.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- LEN_W, 4: burst length width.
- SIZE_W, 3: burst size width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- ARID_M0, ARID_M1  in  ID_W  master read IDs
- ARADDR_M0, ARADDR_M1  in  ADDR_W  master read addresses
- ARLEN_M0, ARLEN_M1  in  LEN_W  burst length minus 1
- ARSIZE_M0, ARSIZE_M1  in  SIZE_W  beat size
- ARBURST_M0, ARBURST_M1  in  2  burst type
- ARVALID_M0, ARVALID_M1  in  1  request valid (already decoded to this slave)
- ARREADY_M0, ARREADY_M1  out  1  request accepted
- RID_M0, RID_M1  out  ID_W  low ID_W bits of RID_S
- RDATA_M0, RDATA_M1  out  DATA_W  read data
- RRESP_M0, RRESP_M1  out  2  response
- RLAST_M0, RLAST_M1  out  1  last beat
- RVALID_M0, RVALID_M1  out  1  beat valid
- RREADY_M0, RREADY_M1  in  1  beat accept
- ARID_S  out  IDS_W  {tag, ARID}; tag = 4'd0 for M0, 4'd1 for M1
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  ADDR_W/LEN_W/SIZE_W/2  registered request
- ARVALID_S  out  1  request valid to slave
- ARREADY_S  in  1  slave accepts request
- RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S  in  IDS_W/DATA_W/2/1/1  slave R channel
- RREADY_S  out  1  beat accept to slave
- len_err  out  1  one-cycle pulse on burst length mismatch

Behaviour:
- Clock is ACLK. Reset is ARESETn: asynchronous, active-low.
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- Registers: state, grant (0 = M0, 1 = M1), last_grant, request registers, beat_cnt (LEN_W bits), len_err.
- Reset:
  - state = IDLE, last_grant = 1 (M0 wins first), beat_cnt = 0, len_err = 0.
  - All ARVALID_S, ARREADY_Mx, RVALID_Mx, RREADY_S outputs = 0.
  - Request registers = 0.
- IDLE:
  - ARREADY_Mx = 1 combinationally only for the winning master.
  - Winner: the single requester if only one ARVALID_Mx is high. If both are high, the master != last_grant.
  - On handshake: latch {tag, ARID}, ARADDR, ARLEN, ARSIZE, ARBURST; set grant; go to ADDR.
  - If no ARVALID_Mx is high, stay in IDLE.
- ADDR:
  - ARVALID_S = 1; fields held stable until ARREADY_S.
  - On ARVALID_S & ARREADY_S: go to DATA, beat_cnt = 0.
  - Minimum latency from master handshake to ARVALID_S is 1 cycle.
- DATA:
  - Granted master: RVALID_Mg = RVALID_S, RREADY_S = RREADY_Mg, RDATA/RRESP/RLAST/RID passed through.
  - Non-granted master: RVALID = 0; RDATA/RRESP/RID = 0.
  - Routing uses the latched grant, never RID_S.
  - Each beat (RVALID_S & RREADY_S) increments beat_cnt.
  - On a beat with RLAST_S = 1: go to IDLE, last_grant = grant.
- Length check: pulse len_err for 1 cycle in either case:
  - RLAST_S beat arrives with beat_cnt != latched ARLEN.
  - A beat with beat_cnt == ARLEN arrives without RLAST_S.
  - Data is still forwarded; the FSM still ends only on RLAST_S.
- ARREADY_Mx = 0 in ADDR and DATA; one outstanding burst only.
- Back-to-back: IDLE is entered the cycle after the last beat, so a new grant can occur in that cycle. Pending requests remain stalled meanwhile.
- A master that deasserts ARVALID before its grant simply loses the arbitration. No state is kept for it.
- R beats arriving in IDLE or ADDR are not forwarded and RREADY_S = 0 (protocol violation by the slave).
- Reset asserted mid-burst: immediate return to the reset state; the in-flight burst is abandoned.

Test Plan:
- Single M0 read: ARADDR_M0 = 0x0000_0010, LEN = 0 -> ARREADY_M0 = 1 in the same cycle; ARVALID_S = 1 next cycle with ARID_S = {4'd0, ARID_M0}; one beat with RLAST -> RVALID_M0 = 1, RVALID_M1 = 0, back to IDLE.
- Simultaneous M0 and M1 requests, repeated 4 times -> grants alternate M0, M1, M0, M1; ARID_S tag = 0, 1, 0, 1.
- M1 burst LEN = 3 with RREADY_M1 low for 2 cycles on beat 2 -> RREADY_S low for those cycles; exactly 4 beats delivered; RLAST_M1 on beat 4 only; M0 request stalled until after beat 4.
- Slave asserts RLAST_S on beat 2 of a LEN = 3 burst -> len_err pulses once; FSM returns to IDLE.
- ARREADY_S held low 5 cycles -> ARVALID_S and ARADDR_S stable throughout; no ARREADY_Mx asserted.
- ARESETn driven low during DATA beat 2 -> all valids low immediately; after release, M0 wins a simultaneous request.
